gate_exerciser: RTL and testbench

//   Drives the two inputs of a 2-input logic gate (nand_1 by default) through all four {a,b} vectors.

---
 rtl/gate_ex_pkg.sv | 32 +++
 rtl/gate_ex_timer.sv | 37 +++
 rtl/gate_exerciser.sv | 148 ++++++++++++++
 tb/tb_gate_exerciser.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/gate_ex_pkg.sv
// Shared types and constants for the gate exerciser: FSM encoding,
// truth tables of common 2-input gates and counter widths.
package gate_ex_pkg;

    localparam int unsigned TIMER_W = 8;
    localparam int unsigned ERR_W   = 3;
    localparam int unsigned IDX_W   = 2;
    localparam int unsigned SWEEP_W = 4;
    localparam int unsigned VEC_N   = 4;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETTLE = 2'd1,
        S_SAMPLE = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    // Expected y indexed by {a,b}: bit0 = 00 ... bit3 = 11
    localparam logic [VEC_N-1:0] TT_NAND = 4'b0111;
    localparam logic [VEC_N-1:0] TT_AND  = 4'b1000;
    localparam logic [VEC_N-1:0] TT_OR   = 4'b1110;
    localparam logic [VEC_N-1:0] TT_NOR  = 4'b0001;
    localparam logic [VEC_N-1:0] TT_XOR  = 4'b0110;

    localparam logic [ERR_W-1:0] ERR_MAX = 3'd7;

    // Increment that sticks at the top of the error counter range
    function automatic logic [ERR_W-1:0] err_inc(input logic [ERR_W-1:0] v);
        return (v == ERR_MAX) ? v : v + ERR_W'(1);
    endfunction

endpackage

// File: rtl/gate_ex_timer.sv
// 8-bit loadable down-counter used as the settle delay.
// expired is high while the count sits at 1 (last settle cycle).
module gate_ex_timer
    import gate_ex_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic [TIMER_W-1:0] value,
    output logic               expired
);

    logic [TIMER_W-1:0] count;
    logic [TIMER_W-1:0] count_next;

    // Load has priority; otherwise count down and rest at zero
    always_comb begin
        count_next = count;
        if (load) begin
            count_next = value;
        end else if (count != '0) begin
            count_next = count - TIMER_W'(1);
        end
    end

    // Count register and registered expiry flag
    always_ff @(posedge clk) begin
        if (rst) begin
            count   <= '0;
            expired <= 1'b0;
        end else begin
            count   <= count_next;
            expired <= (count_next == TIMER_W'(1));
        end
    end

endmodule

// File: rtl/gate_exerciser.sv
// Exercises a 2-input gate with all four {a,b} vectors, samples its output
// after a settle delay and scores it against a truth table.
// Optional build macro GATE_EX_STOP_ON_FAIL_EN: end the run at the first
// mismatching vector instead of completing every sweep.
module gate_exerciser
    import gate_ex_pkg::*;
#(
    parameter logic [VEC_N-1:0] TRUTH  = TT_NAND,
    parameter int unsigned      SETTLE = 2,
    parameter int unsigned      PASSES = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             dut_y,
    output logic             dut_a,
    output logic             dut_b,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_cnt,
    output logic [VEC_N-1:0] fail_vec
);

`ifdef GATE_EX_STOP_ON_FAIL_EN
    localparam bit STOP_ON_FAIL = 1'b1;
`else
    localparam bit STOP_ON_FAIL = 1'b0;
`endif

    localparam logic [SWEEP_W-1:0] LAST_SWEEP = SWEEP_W'(PASSES - 1);
    localparam logic [TIMER_W-1:0] SETTLE_V   = TIMER_W'(SETTLE);
    localparam bit                 NO_SETTLE  = (SETTLE == 0);

    state_t               state;
    state_t               state_next;
    logic [IDX_W-1:0]     idx;
    logic [IDX_W-1:0]     idx_next;
    logic [SWEEP_W-1:0]   sweep;
    logic [SWEEP_W-1:0]   sweep_next;
    logic [ERR_W-1:0]     err_next;
    logic [VEC_N-1:0]     fvec_next;
    logic                 pass_next;
    logic                 busy_next;
    logic                 done_next;
    logic                 timer_load;
    logic                 timer_expired;
    logic                 mismatch;
    logic                 last_vec;

    // Vector drive comes straight from the index register
    assign dut_a = idx[1];
    assign dut_b = idx[0];

    // Settle delay counter, reloaded on entry to each vector
    gate_ex_timer u_timer (
        .clk     (clk),
        .rst     (rst),
        .load    (timer_load),
        .value   (SETTLE_V),
        .expired (timer_expired)
    );

    // State register plus the datapath registers it steers
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            idx      <= '0;
            sweep    <= '0;
            err_cnt  <= '0;
            fail_vec <= '0;
            pass     <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            state    <= state_next;
            idx      <= idx_next;
            sweep    <= sweep_next;
            err_cnt  <= err_next;
            fail_vec <= fvec_next;
            pass     <= pass_next;
            busy     <= busy_next;
            done     <= done_next;
        end
    end

    // Next-state, scoreboard update and registered-output decode
    always_comb begin
        state_next = state;
        idx_next   = idx;
        sweep_next = sweep;
        err_next   = err_cnt;
        fvec_next  = fail_vec;
        pass_next  = pass;
        timer_load = 1'b0;
        mismatch   = 1'b0;
        last_vec   = 1'b0;

        case (state)
            S_IDLE: begin
                if (start) begin
                    err_next   = '0;
                    fvec_next  = '0;
                    pass_next  = 1'b0;
                    idx_next   = '0;
                    sweep_next = '0;
                    timer_load = 1'b1;
                    state_next = NO_SETTLE ? S_SAMPLE : S_SETTLE;
                end
            end
            S_SETTLE: begin
                if (timer_expired) begin
                    state_next = S_SAMPLE;
                end
            end
            S_SAMPLE: begin
                mismatch = (dut_y != TRUTH[idx]);
                last_vec = (idx == IDX_W'(VEC_N - 1)) && (sweep == LAST_SWEEP);
                if (mismatch) begin
                    fvec_next[idx] = 1'b1;
                    err_next       = err_inc(err_cnt);
                end
                if (last_vec || (STOP_ON_FAIL && mismatch)) begin
                    // pass is settled on entry to DONE so it is valid with the done pulse
                    pass_next  = (err_next == '0);
                    state_next = S_DONE;
                end else begin
                    idx_next   = idx + IDX_W'(1);
                    if (idx == IDX_W'(VEC_N - 1)) begin
                        sweep_next = sweep + SWEEP_W'(1);
                    end
                    timer_load = 1'b1;
                    state_next = NO_SETTLE ? S_SAMPLE : S_SETTLE;
                end
            end
            S_DONE: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase

        busy_next = (state_next == S_SETTLE) || (state_next == S_SAMPLE);
        done_next = (state_next == S_DONE);
    end

endmodule

// File: tb/tb_gate_exerciser.sv
// Scoreboard bench for gate_exerciser: three instances with different
// truth table / settle / pass settings, each driven by a behavioural gate
// model that can be forced good, stuck-at-1, stuck-at-0 or wrong on {0,1}.
module tb_gate_exerciser;
    import gate_ex_pkg::*;

    localparam int NI = 3;

`ifdef GATE_EX_STOP_ON_FAIL_EN
    localparam bit SOF = 1'b1;
`else
    localparam bit SOF = 1'b0;
`endif

    typedef struct {
        int   inst;
        logic pass;
        int   err;
        int   fvec;
        int   lat;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst;
    logic [NI-1:0]   start;
    logic [NI-1:0]   dut_y;
    logic [NI-1:0]   dut_a;
    logic [NI-1:0]   dut_b;
    logic [NI-1:0]   busy;
    logic [NI-1:0]   done;
    logic [NI-1:0]   pass;
    logic [2:0]      err_cnt  [NI];
    logic [3:0]      fail_vec [NI];
    int              mode     [NI];
    int              hold     [NI];

    exp_t            sb_q[$];
    int              total = 0;
    int              bad   = 0;
    int              cyc   = 0;

    always #5 clk = ~clk;

    // inst 0: NAND, default settle/passes
    gate_exerciser u_nand (
        .clk(clk), .rst(rst), .start(start[0]), .dut_y(dut_y[0]),
        .dut_a(dut_a[0]), .dut_b(dut_b[0]), .busy(busy[0]), .done(done[0]),
        .pass(pass[0]), .err_cnt(err_cnt[0]), .fail_vec(fail_vec[0])
    );

    // inst 1: NAND, SETTLE=1, three sweeps
    gate_exerciser #(.TRUTH(TT_NAND), .SETTLE(1), .PASSES(3)) u_p3 (
        .clk(clk), .rst(rst), .start(start[1]), .dut_y(dut_y[1]),
        .dut_a(dut_a[1]), .dut_b(dut_b[1]), .busy(busy[1]), .done(done[1]),
        .pass(pass[1]), .err_cnt(err_cnt[1]), .fail_vec(fail_vec[1])
    );

    // inst 2: XOR, no settle cycles
    gate_exerciser #(.TRUTH(TT_XOR), .SETTLE(0), .PASSES(1)) u_xor (
        .clk(clk), .rst(rst), .start(start[2]), .dut_y(dut_y[2]),
        .dut_a(dut_a[2]), .dut_b(dut_b[2]), .busy(busy[2]), .done(done[2]),
        .pass(pass[2]), .err_cnt(err_cnt[2]), .fail_vec(fail_vec[2])
    );

    function automatic logic model_y(input int inst, input int m, input logic a, input logic b);
        logic good;
        good = (inst == 2) ? (a ^ b) : ~(a & b);
        case (m)
            1:       return 1'b1;
            2:       return 1'b0;
            3:       return (~a & b) ? ~good : good;
            default: return good;
        endcase
    endfunction

    always_comb begin
        for (int i = 0; i < NI; i++) begin
            dut_y[i] = model_y(i, mode[i], dut_a[i], dut_b[i]);
        end
    end

    task automatic chk(input string nm, input int act, input int exp_v);
        total++;
        if (act !== exp_v) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp_v, cyc);
        end
    endtask

    // Monitor: vector sequence while busy, scoreboard pop on every done
    initial begin : monitor
        logic [NI-1:0] busy_prev;
        int            t0 [NI];
        exp_t          e;
        busy_prev = '0;
        for (int i = 0; i < NI; i++) t0[i] = 0;
        forever begin
            @(negedge clk);
            cyc++;
            for (int i = 0; i < NI; i++) begin
                if (busy[i] && !busy_prev[i]) t0[i] = cyc;
                if (busy[i]) begin
                    chk($sformatf("ab_seq%0d", i), int'({dut_a[i], dut_b[i]}),
                        ((cyc - t0[i]) / hold[i]) % 4);
                end
                if (done[i]) begin
                    chk($sformatf("done_owner%0d", i), i,
                        (sb_q.size() == 0) ? -1 : sb_q[0].inst);
                    if (sb_q.size() != 0 && sb_q[0].inst == i) begin
                        e = sb_q.pop_front();
                        chk($sformatf("pass%0d", i),     int'(pass[i]), int'(e.pass));
                        chk($sformatf("err_cnt%0d", i),  int'(err_cnt[i]), e.err);
                        chk($sformatf("fail_vec%0d", i), int'(fail_vec[i]), e.fvec);
                        chk($sformatf("latency%0d", i),  cyc - t0[i], e.lat);
                        chk($sformatf("busy_at_done%0d", i), int'(busy[i]), 0);
                    end
                end
                busy_prev[i] = busy[i];
            end
        end
    end

    task automatic push(input int inst, input logic p, input int err, input int fvec, input int lat);
        exp_t e;
        e.inst = inst; e.pass = p; e.err = err; e.fvec = fvec; e.lat = lat;
        sb_q.push_back(e);
    endtask

    task automatic pulse_start(input int inst);
        @(negedge clk);
        start[inst] = 1'b1;
        @(negedge clk);
        start[inst] = 1'b0;
    endtask

    // Wait for the scoreboard to empty, noting whether {a,b}=10 was ever driven
    task automatic drain(input string nm, input int inst, input int bound, output logic saw10);
        int n;
        n = 0;
        saw10 = 1'b0;
        while (sb_q.size() != 0 && n < bound) begin
            if (dut_a[inst] && !dut_b[inst]) saw10 = 1'b1;
            @(negedge clk);
            n++;
        end
        chk({nm, "_drained"}, sb_q.size(), 0);
        repeat (3) @(negedge clk);
    endtask

    task automatic run(input string nm, input int inst, input int m, input logic p,
                       input int err, input int fvec, input int lat, output logic saw10);
        mode[inst] = m;
        push(inst, p, err, fvec, lat);
        pulse_start(inst);
        drain(nm, inst, 200, saw10);
    endtask

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        logic saw10;
        int   n;
        hold[0] = 3; hold[1] = 2; hold[2] = 1;
        rst   = 1'b1;
        start = '0;
        for (int i = 0; i < NI; i++) mode[i] = 0;
        repeat (3) @(negedge clk);

        // Reset state
        for (int i = 0; i < NI; i++) begin
            chk($sformatf("rst_busy%0d", i), int'(busy[i]), 0);
            chk($sformatf("rst_done%0d", i), int'(done[i]), 0);
            chk($sformatf("rst_pass%0d", i), int'(pass[i]), 0);
            chk($sformatf("rst_err%0d", i),  int'(err_cnt[i]), 0);
            chk($sformatf("rst_fvec%0d", i), int'(fail_vec[i]), 0);
            chk($sformatf("rst_ab%0d", i),   int'({dut_a[i], dut_b[i]}), 0);
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Good NAND: 12 busy cycles then done
        run("good_nand", 0, 0, 1'b1, 0, 0, 12, saw10);
        chk("pass_held", int'(pass[0]), 1);

        // Stuck-at-1: only vector 11 disagrees, so the run ends at the same time either way
        run("stuck1", 0, 1, 1'b0, 1, 4'b1000, 12, saw10);

        // Three sweeps stuck-at-0: 9 mismatches saturate at 7
        if (SOF) run("p3_stuck0", 1, 2, 1'b0, 1, 4'b0001, 2, saw10);
        else     run("p3_stuck0", 1, 2, 1'b0, 7, 4'b0111, 24, saw10);
        run("p3_good", 1, 0, 1'b1, 0, 0, 24, saw10);

        // Reset mid-sweep at idx=2 aborts without done
        mode[0] = 0;
        pulse_start(0);
        n = 0;
        while (!(dut_a[0] && !dut_b[0]) && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("reach_idx2", int'({dut_a[0], dut_b[0]}), 2);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_busy", int'(busy[0]), 0);
        chk("abort_ab",   int'({dut_a[0], dut_b[0]}), 0);
        chk("abort_err",  int'(err_cnt[0]), 0);
        chk("abort_fvec", int'(fail_vec[0]), 0);
        chk("abort_pass_other", int'(pass[1]), 0);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        run("after_abort", 0, 0, 1'b1, 0, 0, 12, saw10);

        // start pulses during busy are ignored: one run, one done
        push(0, 1'b1, 0, 0, 12);
        pulse_start(0);
        repeat (2) begin
            pulse_start(0);
            @(negedge clk);
        end
        pulse_start(0);
        drain("busy_starts", 0, 200, saw10);

        // start held across DONE relaunches from the following IDLE cycle
        push(0, 1'b1, 0, 0, 12);
        push(0, 1'b1, 0, 0, 12);
        @(negedge clk);
        start[0] = 1'b1;
        n = 0;
        @(negedge clk);
        while (!done[0] && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("held_first_done", int'(done[0]), 1);
        n = 0;
        while (!busy[0] && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("relaunch_gap", n, 2);
        start[0] = 1'b0;
        drain("held_start", 0, 200, saw10);

        // Zero settle cycles, XOR truth table
        run("xor_good", 2, 0, 1'b1, 0, 0, 4, saw10);
        run("xor_bad01", 2, 3, 1'b0, 1, 4'b0010, SOF ? 2 : 4, saw10);

        // NAND wrong only on vector 01
        run("nand_bad01", 0, 3, 1'b0, 1, 4'b0010, SOF ? 6 : 12, saw10);
        chk("reached_10", int'(saw10), SOF ? 0 : 1);

        repeat (5) @(negedge clk);
        chk("queue_empty_end", sb_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
